imm_extend_pipe: RTL and testbench
==================================

Name: imm_extend_pipe

Overview:
- Parametrised, pipelined immediate extender for the datapath's decode/execute boundary.
- Takes an IN_WIDTH immediate plus a mode select and produces an OUT_WIDTH operand by one of four modes: zero-extend, sign-extend, sign-extend-shift-left-1 (branch offset) or high-placement.
- Results pass through a 2-entry valid/ready skid buffer, so downstream stalls never drop or reorder immediates.

Parameters:
- IN_WIDTH, 4, width of the incoming immediate field; legal range is 2 or more.
- OUT_WIDTH, 16, width of the extended operand; must be at least IN_WIDTH+1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  the in_imm/in_mode pair is valid this cycle.
- in_ready  output  1  the block can accept an input this cycle.
- in_imm  input  IN_WIDTH  raw immediate field.
- in_mode  input  2  extension mode: 00 ZERO, 01 SIGN, 10 SIGN_SHL1, 11 HIGH.
- out_valid  output  1  out_data holds a valid result.
- out_ready  input  1  the consumer accepts out_data this cycle.
- out_data  output  OUT_WIDTH  extended operand.

Behaviour:
- The clock and reset are fixed as: one clock, clk; reset rst is asynchronous and active-high.
- Extension is combinational on in_imm/in_mode. The sign bit is in_imm[IN_WIDTH-1].
  - ZERO: out = {(OUT_WIDTH-IN_WIDTH) zeros, in_imm}.
  - SIGN: out = {(OUT_WIDTH-IN_WIDTH) copies of sign, in_imm}.
  - SIGN_SHL1: the SIGN result shifted left by 1 with LSB 0; the bit shifted out of the MSB is discarded; the result stays OUT_WIDTH wide.
  - HIGH: in_imm occupies bits [OUT_WIDTH-1 : OUT_WIDTH-IN_WIDTH]; all lower bits are 0.
- A transfer occurs on a rising edge when valid and ready are both high on that side.
- Storage is two OUT_WIDTH registers: main, which drives out_data, and skid.
- State machine:
  - EMPTY: out_valid=0. An input transfer loads main and moves to ONE.
  - ONE: out_valid=1.
    - Input without output goes to TWO, with the new result in skid.
    - Output without input goes to EMPTY.
    - Input and output together load main with the new result and stay in ONE.
  - TWO: in_ready=0, out_valid=1. An output transfer copies skid to main and moves to ONE.
- in_ready = (state != TWO) and not rst.
- out_valid = (state != EMPTY).
- Latency: a result accepted at edge N is presented on out_data immediately after edge N.
- Throughput: one result per cycle when out_ready is held high.
- Ordering is strictly FIFO.
- While out_valid is high and out_ready is low, out_data must remain stable.
- Reset values: state=EMPTY, main=0, skid=0, out_valid=0, out_data=0, in_ready=0 while rst is high.
- Reset mid-operation: any buffered entries are discarded immediately; there is no output transfer during reset. in_ready returns to 1 in the first cycle after rst deasserts.
- in_valid while in_ready=0: no transfer; the input is ignored. The producer must hold its data.

Decomposition:
- Shared package/header holds:
  - mode encodings: MODE_ZERO=2'b00, MODE_SIGN=2'b01, MODE_SIGN_SHL1=2'b10, MODE_HIGH=2'b11;
  - state encodings: EMPTY, ONE, TWO as 2-bit localparams.
- One natural sub-module, imm_extend_core: purely combinational, parametrised by IN_WIDTH/OUT_WIDTH, mapping in_imm and mode to the extended value.
- The top level holds the skid buffer and the FSM.

Test Plan:
- Mode sweep (defaults 4/16), in_imm=4'b1010, out_ready=1 -> ZERO 16'h000A, SIGN 16'hFFFA, SIGN_SHL1 16'hFFF4, HIGH 16'hA000, each 1 cycle after acceptance. Repeat with in_imm=4'b0101 in SIGN -> 16'h0005.
- Streaming: 8 back-to-back SIGN inputs 0..7 with out_ready=1 -> in_ready stays 1; outputs 16'h0000..16'h0007 in order, one per cycle.
- Backpressure: out_ready=0, present inputs A=4'h3, B=4'h9, C=4'h1 (SIGN):
  - A and B are accepted; in_ready drops after B; C is held off.
  - out_data stays 16'h0003.
  - Raise out_ready: outputs are 16'h0003, 16'hFFF9, then 16'h0001 after C is accepted.
- Simultaneous accept/drain in ONE with alternating out_ready -> never enters TWO when out_ready=1; no loss and no duplication across 20 random-mode transfers checked against a reference model.
- Reset mid-operation: fill to TWO, assert rst asynchronously between edges -> out_valid and out_data go to 0 immediately. After release, in_ready=1 and the first new input 4'hF SIGN yields 16'hFFFF.
- Parameter variant IN_WIDTH=8, OUT_WIDTH=32: in_imm=8'h80 -> SIGN 32'hFFFFFF80, SIGN_SHL1 32'hFFFFFF00, HIGH 32'h80000000, ZERO 32'h00000080.

Source files
------------

// File: rtl/imm_extend_pkg.sv
// imm_extend_pkg: mode and state encodings shared by the immediate extender
package imm_extend_pkg;
   localparam logic [1:0] MODE_ZERO      = 2'b00;
   localparam logic [1:0] MODE_SIGN      = 2'b01;
   localparam logic [1:0] MODE_SIGN_SHL1 = 2'b10;
   localparam logic [1:0] MODE_HIGH      = 2'b11;
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;
endpackage

// File: rtl/imm_extend_core.sv
// imm_extend_core: combinational zero/sign/branch-offset/high immediate extension
module imm_extend_core
   import imm_extend_pkg::*;
#(
   parameter int IN_WIDTH  = 4,
   parameter int OUT_WIDTH = 16
) (
   input  logic [IN_WIDTH-1:0]  imm,
   input  logic [1:0]           mode,
   output logic [OUT_WIDTH-1:0] ext
);
   localparam int PAD = OUT_WIDTH - IN_WIDTH;
   logic [OUT_WIDTH-1:0] zext, sext, hext;
   assign zext = {{PAD{1'b0}}, imm};
   assign sext = {{PAD{imm[IN_WIDTH-1]}}, imm};
   assign hext = {imm, {PAD{1'b0}}};
   // branch offsets drop the top sign copy so the result keeps OUT_WIDTH bits
   always_comb begin
      ext = mode == MODE_ZERO      ? zext :
            mode == MODE_SIGN      ? sext :
            mode == MODE_SIGN_SHL1 ? {sext[OUT_WIDTH-2:0], 1'b0} : hext;
   end
endmodule

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: immediate extender feeding a 2-entry valid/ready skid buffer
module imm_extend_pipe
   import imm_extend_pkg::*;
#(
   parameter int IN_WIDTH  = 4,
   parameter int OUT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [IN_WIDTH-1:0]  in_imm,
   input  logic [1:0]           in_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_WIDTH-1:0] out_data
);
   logic [1:0]           state_q, state_d;
   logic [OUT_WIDTH-1:0] main_q, main_d, skid_q, skid_d, ext;
   logic                 in_fire, out_fire;
   imm_extend_core #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_core (
      .imm  (in_imm),
      .mode (in_mode),
      .ext  (ext)
   );
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_EMPTY;
      else     state_q <= state_d;
   end
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_EMPTY: state_d = in_fire ? ST_ONE : ST_EMPTY;
         ST_ONE:   state_d = (in_fire && !out_fire) ? ST_TWO :
                             (!in_fire && out_fire) ? ST_EMPTY : ST_ONE;
         ST_TWO:   state_d = out_fire ? ST_ONE : ST_TWO;
         default:  state_d = ST_EMPTY;
      endcase
   end
   always_comb begin
      in_ready  = (state_q != ST_TWO) && !rst;
      out_valid = state_q != ST_EMPTY;
      out_data  = main_q;
   end
   // main takes the new result only when it is free or being drained this edge
   always_comb begin
      main_d = main_q;
      skid_d = skid_q;
      if (state_q == ST_TWO) main_d = out_fire ? skid_q : main_q;
      else if (in_fire && (state_q == ST_EMPTY || out_fire)) main_d = ext;
      else if (in_fire) skid_d = ext;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         main_q <= main_d;
         skid_q <= skid_d;
      end
   end
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: directed checks of extension modes, skid buffering and reset
module tb_imm_extend_pipe;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
   logic [3:0]  in_imm = '0;
   logic [1:0]  in_mode = '0;
   logic [15:0] out_data;
   logic        v_in_valid = 1'b0, v_in_ready, v_out_valid, v_out_ready = 1'b1;
   logic [7:0]  v_in_imm = '0;
   logic [1:0]  v_in_mode = '0;
   logic [31:0] v_out_data;
   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   imm_extend_pipe dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_imm(in_imm), .in_mode(in_mode), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data)
   );

   imm_extend_pipe #(.IN_WIDTH(8), .OUT_WIDTH(32)) dut8 (
      .clk(clk), .rst(rst), .in_valid(v_in_valid), .in_ready(v_in_ready),
      .in_imm(v_in_imm), .in_mode(v_in_mode), .out_valid(v_out_valid),
      .out_ready(v_out_ready), .out_data(v_out_data)
   );

   function automatic logic [15:0] model(input logic [3:0] imm, input logic [1:0] mode);
      logic [15:0] s;
      s = imm[3] ? (16'hFFF0 | 16'(imm)) : 16'(imm);
      case (mode)
         2'b00:   return 16'(imm);
         2'b01:   return s;
         2'b10:   return s << 1;
         default: return 16'(imm) << 12;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1;
      n_vec++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'h0) begin
         n_err++;
         $display("FAIL reset: in_ready=%b out_valid=%b out_data=%h want 0 0 0000", in_ready, out_valid, out_data);
      end
      step();
      rst = 1'b0;
      #1;
      n_vec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_modes();
      logic [15:0] exp_v [5] = '{16'h000A, 16'hFFFA, 16'hFFF4, 16'hA000, 16'h0005};
      logic [3:0]  imm_v [5] = '{4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b0101};
      logic [1:0]  mode_v [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01};
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_imm   = imm_v[i];
         in_mode  = mode_v[i];
         step();
         n_vec++;
         if (out_valid !== 1'b1 || out_data !== exp_v[i]) begin
            n_err++;
            $display("FAIL mode_%0d: valid=%b data=%h want 1 %h", i, out_valid, out_data, exp_v[i]);
         end
      end
      in_valid = 1'b0;
      step();
   endtask

   task automatic test_streaming();
      out_ready = 1'b1;
      in_mode   = 2'b01;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_imm   = 4'(i);
         #1;
         n_vec++;
         if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL stream_ready_%0d: in_ready=%b want 1", i, in_ready);
         end
         step();
         n_vec++;
         if (out_valid !== 1'b1 || out_data !== 16'(i)) begin
            n_err++;
            $display("FAIL stream_%0d: valid=%b data=%h want 1 %h", i, out_valid, out_data, 16'(i));
         end
      end
      in_valid = 1'b0;
      step();
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL stream_drain: out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      in_mode   = 2'b01;
      in_valid  = 1'b1;
      in_imm    = 4'h3;
      step();
      in_imm = 4'h9;
      n_vec++;
      if (in_ready !== 1'b1 || out_data !== 16'h0003) begin
         n_err++;
         $display("FAIL bp_a: in_ready=%b data=%h want 1 0003", in_ready, out_data);
      end
      step();
      in_imm = 4'h1;
      n_vec++;
      if (in_ready !== 1'b0 || out_data !== 16'h0003) begin
         n_err++;
         $display("FAIL bp_full: in_ready=%b data=%h want 0 0003", in_ready, out_data);
      end
      step();
      n_vec++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'h0003) begin
         n_err++;
         $display("FAIL bp_hold: in_ready=%b valid=%b data=%h want 0 1 0003", in_ready, out_valid, out_data);
      end
      out_ready = 1'b1;
      step();
      n_vec++;
      if (in_ready !== 1'b1 || out_data !== 16'hFFF9) begin
         n_err++;
         $display("FAIL bp_b: in_ready=%b data=%h want 1 fff9", in_ready, out_data);
      end
      step();
      in_valid = 1'b0;
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== 16'h0001) begin
         n_err++;
         $display("FAIL bp_c: valid=%b data=%h want 1 0001", out_valid, out_data);
      end
      step();
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL bp_empty: out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_alternating();
      logic [15:0] q[$];
      logic [15:0] exp;
      logic fi, fo, prev_ok;
      int accepted = 0;
      int cycles = 0;
      while (accepted < 20 && cycles < 200) begin
         in_valid  = 1'b1;
         in_imm    = 4'($urandom);
         in_mode   = 2'($urandom);
         out_ready = cycles[0];
         #1;
         fi = in_valid && in_ready;
         fo = out_valid && out_ready;
         prev_ok = out_ready && in_ready;
         exp = model(in_imm, in_mode);
         if (fo) begin
            n_vec++;
            if (q.size() == 0) begin
               n_err++;
               $display("FAIL alt_dup: data=%h with empty model", out_data);
            end else if (out_data !== q[0]) begin
               n_err++;
               $display("FAIL alt_data: data=%h want %h", out_data, q[0]);
            end
            if (q.size() != 0) void'(q.pop_front());
         end
         step();
         if (fi) begin
            q.push_back(exp);
            accepted++;
         end
         if (prev_ok) begin
            n_vec++;
            if (in_ready !== 1'b1) begin
               n_err++;
               $display("FAIL alt_two: in_ready=%b want 1 after drain+accept", in_ready);
            end
         end
         cycles++;
      end
      n_vec++;
      if (accepted != 20) begin
         n_err++;
         $display("FAIL alt_timeout: accepted=%0d want 20", accepted);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         if (out_valid) begin
            n_vec++;
            if (q.size() == 0 || out_data !== q[0]) begin
               n_err++;
               $display("FAIL alt_drain: data=%h want %h", out_data, q.size() ? q[0] : 16'hxxxx);
            end
            if (q.size() != 0) void'(q.pop_front());
         end
         step();
      end
      n_vec++;
      if (q.size() != 0 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL alt_loss: left=%0d valid=%b want 0 0", q.size(), out_valid);
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_mode   = 2'b01;
      in_imm    = 4'h5;
      step();
      in_imm = 4'h6;
      step();
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      n_vec++;
      if (out_valid !== 1'b0 || out_data !== 16'h0 || in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL rst_mid: valid=%b data=%h in_ready=%b want 0 0000 0", out_valid, out_data, in_ready);
      end
      step();
      rst = 1'b0;
      #1;
      n_vec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL rst_mid_release: in_ready=%b valid=%b want 1 0", in_ready, out_valid);
      end
      in_valid  = 1'b1;
      in_imm    = 4'hF;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== 16'hFFFF) begin
         n_err++;
         $display("FAIL rst_mid_first: valid=%b data=%h want 1 ffff", out_valid, out_data);
      end
      step();
   endtask

   task automatic test_wide();
      logic [31:0] exp_v [4] = '{32'h00000080, 32'hFFFFFF80, 32'hFFFFFF00, 32'h80000000};
      v_out_ready = 1'b1;
      v_in_imm    = 8'h80;
      for (int i = 0; i < 4; i++) begin
         v_in_valid = 1'b1;
         v_in_mode  = 2'(i);
         step();
         n_vec++;
         if (v_out_valid !== 1'b1 || v_out_data !== exp_v[i]) begin
            n_err++;
            $display("FAIL wide_mode_%0d: valid=%b data=%h want 1 %h", i, v_out_valid, v_out_data, exp_v[i]);
         end
      end
      v_in_valid = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_modes();
      test_streaming();
      test_backpressure();
      test_alternating();
      test_reset_mid();
      test_wide();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
